// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM with one-cycle registered
// reads, plus an I/O window (UART RX pop, TX FIFO push, cycle counter, stop flag).
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_done,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TX_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [7:0] fifo_mem [0:TX_DEPTH-1];

    logic [7:0]    mem_din_d, mem_din_q;
    logic          rx_pop_d, rx_pop_q;
    logic          program_done_d, program_done_q;
    logic          tx_overflow_d, tx_overflow_q;
    logic          full_d, full_q;
    logic [31:0]   counter_d, counter_q;
    logic [31:0]   snap_d, snap_q;
    logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;

    logic                      io_sel;
    logic [15:0]               io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      ram_we;
    logic                      push_req, push_ok, pop;
    logic [7:0]                push_byte;
    logic                      unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign io_off      = mem_a[15:0];
    assign ram_idx     = mem_a[RAM_ADDR_WIDTH-1:0];
    assign ram_we      = rdy_in & mem_wr & ~io_sel;
    assign unused_addr = &{1'b0, mem_a[31:18]};

    assign tx_valid = (count_q != '0);
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign pop      = tx_valid & tx_ready;

    // CPU-facing decode; everything here is gated by rdy_in.
    always_comb begin
        mem_din_d      = mem_din_q;
        rx_pop_d       = 1'b0;
        snap_d         = snap_q;
        program_done_d = program_done_q;
        push_req       = 1'b0;
        push_byte      = mem_dout;
        counter_d      = rdy_in ? counter_q + 32'd1 : counter_q;
        if (rdy_in) begin
            if (!io_sel) begin
                if (!mem_wr) mem_din_d = ram[ram_idx];
            end else if (!mem_wr) begin
                mem_din_d = 8'h00;
                case (io_off)
                    16'h0000: if (rx_valid) begin
                        mem_din_d = rx_data;
                        rx_pop_d  = 1'b1;
                    end
                    16'h0004: begin
                        mem_din_d = counter_q[7:0];
                        snap_d    = counter_q;
                    end
                    16'h0005: mem_din_d = snap_q[15:8];
                    16'h0006: mem_din_d = snap_q[23:16];
                    16'h0007: mem_din_d = snap_q[31:24];
                    default:  mem_din_d = 8'h00;
                endcase
            end else begin
                case (io_off)
                    16'h0000: push_req = (mem_dout != 8'h00);
                    16'h0004: begin
                        program_done_d = 1'b1;
                        push_req       = 1'b1;
                        push_byte      = 8'h00;
                    end
                    default: push_req = 1'b0;
                endcase
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        push_ok       = push_req & ((count_q != DEPTH_C) | pop);
        tx_overflow_d = tx_overflow_q | (push_req & ~push_ok);
        wr_ptr_d      = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d       = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d >= FULL_LVL);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q      <= 8'h00;
            rx_pop_q       <= 1'b0;
            program_done_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
            full_q         <= 1'b0;
            counter_q      <= 32'd0;
            snap_q         <= 32'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            mem_din_q      <= mem_din_d;
            rx_pop_q       <= rx_pop_d;
            program_done_q <= program_done_d;
            tx_overflow_q  <= tx_overflow_d;
            full_q         <= full_d;
            counter_q      <= counter_d;
            snap_q         <= snap_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage arrays are never reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= mem_dout;
        if (push_ok) fifo_mem[wr_ptr_q] <= push_byte;
    end

    assign mem_din        = mem_din_q;
    assign rx_pop         = rx_pop_q;
    assign program_done   = program_done_q;
    assign tx_overflow    = tx_overflow_q;
    assign io_buffer_full = full_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM access, stalls, RX/TX I/O, reset and counter wrap.
module tb_mem_io_responder;
    localparam logic [31:0] IDLE_A = 32'h0000_0100;

    logic        clk, rst, rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout, mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_pop;
    logic        program_done, tx_overflow;

    int checks = 0;
    int failures = 0;
    logic [31:0] cnt_model;
    logic [31:0] pre;

    mem_io_responder dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_done(program_done), .tx_overflow(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: edges with rdy_in high since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_model <= 32'd0;
        else if (rdy_in) cnt_model <= cnt_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_wr = 1'b1; mem_dout = d; rdy_in = 1'b1;
        @(negedge clk);
        mem_wr = 1'b0; mem_dout = 8'h00; mem_a = IDLE_A;
    endtask

    task automatic do_read(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0; rdy_in = 1'b1;
        @(negedge clk);
        mem_a = IDLE_A;
    endtask

    initial begin
        rst = 1'b1; rdy_in = 1'b0; mem_a = IDLE_A; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_din", mem_din, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_full", io_buffer_full, 0);
        check("rst_done", program_done, 0);
        check("rst_ovf", tx_overflow, 0);
        check("rst_rx_pop", rx_pop, 0);
        rst = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk);

        // RAM writes/reads, including the top byte and write-then-read.
        do_write(32'h0000_0010, 8'hA5);
        do_write(32'h0001_FFFF, 8'h3C);
        do_read(32'h0000_0010);
        check("ram_rd_10", mem_din, 8'hA5);
        do_read(32'h0001_FFFF);
        check("ram_rd_1ffff", mem_din, 8'h3C);
        do_write(32'h0000_0010, 8'h77);
        do_read(32'h0000_0010);
        check("ram_rd_after_wr", mem_din, 8'h77);

        // Stall: writes, counter and mem_din all frozen while rdy_in is low.
        do_write(32'h0000_0020, 8'h5A);
        do_read(32'h0000_0020);
        check("ram_rd_20", mem_din, 8'h5A);
        rdy_in = 1'b0; mem_a = 32'h0000_0020; mem_wr = 1'b1; mem_dout = 8'hFF;
        pre = cnt_model;
        repeat (5) @(negedge clk);
        check("stall_mem_din", mem_din, 8'h5A);
        mem_wr = 1'b0; mem_dout = 8'h00;
        do_read(32'h0003_0004);
        check("stall_cnt_b0", mem_din, {24'd0, pre[7:0]});
        do_read(32'h0003_0005);
        check("stall_cnt_b1", mem_din, {24'd0, pre[15:8]});
        do_read(32'h0003_0006);
        check("stall_cnt_b2", mem_din, {24'd0, pre[23:16]});
        do_read(32'h0003_0007);
        check("stall_cnt_b3", mem_din, {24'd0, pre[31:24]});
        do_read(32'h0000_0020);
        check("stall_ram_kept", mem_din, 8'h5A);

        // UART RX pop.
        rx_valid = 1'b1; rx_data = 8'h41;
        do_read(32'h0003_0000);
        check("rx_data", mem_din, 8'h41);
        check("rx_pop_hi", rx_pop, 1);
        rx_valid = 1'b0;
        @(negedge clk);
        check("rx_pop_lo", rx_pop, 0);
        do_read(32'h0003_0000);
        check("rx_empty_data", mem_din, 0);
        check("rx_empty_pop", rx_pop, 0);

        // Unmapped I/O offsets.
        do_read(32'h0000_0010);
        do_read(32'h0003_0008);
        check("io_unmapped_rd", mem_din, 0);
        do_write(32'h0003_0010, 8'h44);
        check("io_unmapped_wr", tx_valid, 0);

        // TX FIFO fill, near-full, overflow, zero suppression, drain order.
        for (int i = 1; i <= 8; i++) begin
            do_write(32'h0003_0000, 8'(i));
            if (i == 5) check("full_after5", io_buffer_full, 0);
            if (i == 6) check("full_after6", io_buffer_full, 1);
        end
        check("tx_valid_filled", tx_valid, 1);
        check("ovf_before9", tx_overflow, 0);
        do_write(32'h0003_0000, 8'h09);
        check("ovf_after9", tx_overflow, 1);
        do_write(32'h0003_0000, 8'h00);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), tx_valid, 1);
            check($sformatf("drain_data_%0d", i), tx_data, i);
            @(negedge clk);
        end
        check("drain_empty", tx_valid, 0);
        check("drain_not_full", io_buffer_full, 0);
        tx_ready = 1'b0;

        // Stop write queues a zero after earlier bytes.
        do_write(32'h0003_0000, 8'h11);
        do_write(32'h0003_0004, 8'h55);
        check("program_done", program_done, 1);
        tx_ready = 1'b1;
        check("stop_q_first", tx_data, 8'h11);
        @(negedge clk);
        check("stop_q_valid", tx_valid, 1);
        check("stop_q_zero", tx_data, 8'h00);
        @(negedge clk);
        check("stop_q_empty", tx_valid, 0);
        tx_ready = 1'b0;

        // Asynchronous reset with bytes queued and mem_din non-zero.
        do_write(32'h0003_0000, 8'h22);
        do_write(32'h0003_0000, 8'h33);
        do_read(32'h0000_0010);
        check("pre_rst_din", mem_din, 8'h77);
        rdy_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_done", program_done, 0);
        check("arst_din", mem_din, 0);
        check("arst_ovf", tx_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h0000_0010);
        check("ram_survives_rst", mem_din, 8'h77);

        // Counter wrap, forced near the top.
        rdy_in = 1'b0;
        force dut.counter_q = 32'hFFFF_FFFE;
        #1 release dut.counter_q;
        @(negedge clk);
        do_read(32'h0003_0004);
        check("near_wrap_b0", mem_din, 8'hFE);
        do_read(32'h0003_0007);
        check("near_wrap_b3", mem_din, 8'hFF);
        rdy_in = 1'b0;
        force dut.counter_q = 32'hFFFF_FFFE;
        #1 release dut.counter_q;
        @(negedge clk);
        rdy_in = 1'b1; mem_a = IDLE_A;
        repeat (2) @(negedge clk);
        for (int k = 4; k <= 7; k++) begin
            do_read(32'h0003_0000 + 32'(k));
            check($sformatf("wrap_b%0d", k - 4), mem_din, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (address, write strobe, data out from CPU; data in to CPU).
- Provides 128 KB byte RAM with registered one-cycle read latency.
- Provides the I/O window at mem_a[17:16]==2'b11: UART RX pop, UART TX push through a small FIFO, cycle counter, and program-stop flag.
- Sits opposite the CPU's cache/memory controller and is the block the CPU simulation and FPGA top instantiate against.

Parameters:
- RAM_ADDR_WIDTH, 17, byte-address width of RAM (2^17 bytes).
- TX_DEPTH, 8, TX FIFO entries, power of two.
- FULL_MARGIN, 2, free-slot slack at which io_buffer_full asserts.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous reset, active-high.
- rdy_in  input  1  bus enable; low freezes all CPU-facing state.
- mem_a  input  32  byte address from CPU; only bits 17:0 decoded.
- mem_wr  input  1  1 = write, 0 = read.
- mem_dout  input  8  write data from CPU.
- mem_din  output  8  read data to CPU, registered.
- io_buffer_full  output  1  TX FIFO near full.
- tx_data  output  8  FIFO head byte to UART transmitter.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  UART accepts head this cycle.
- rx_data  input  8  UART received byte.
- rx_valid  input  1  rx_data holds an unread byte.
- rx_pop  output  1  one-cycle pulse consuming rx_data.
- program_done  output  1  sticky stop flag.
- tx_overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Reset is asynchronous and active-high on rst_in, clocked by clk_in. Reset clears: mem_din=0, rx_pop=0, program_done=0, tx_overflow=0, FIFO pointers and count=0 (so tx_valid=0, io_buffer_full=0), cycle counter=0, counter snapshot=0. RAM contents are not cleared. Reset mid-transfer discards queued TX bytes.
- Decode: io_sel = (mem_a[17:16]==2'b11). RAM index = mem_a[RAM_ADDR_WIDTH-1:0] when !io_sel.
- All CPU-side actions happen only on edges with rdy_in=1. With rdy_in=0: no RAM write, mem_din holds, rx_pop=0, no push, counter holds. The TX pop side ignores rdy_in.
- Cycle counter: 32-bit, +1 each rdy_in=1 edge, wraps 0xFFFFFFFF->0.
- RAM write (!io_sel, mem_wr=1): ram[idx] <= mem_dout at that edge. mem_din holds its value.
- RAM read (!io_sel, mem_wr=0): mem_din <= ram[idx] at that edge; data is valid the cycle after the address is presented. A read of a byte written on the previous edge returns the new data.
- IO read 0x30000: if rx_valid, mem_din <= rx_data and rx_pop=1 for exactly that cycle; else mem_din <= 0 and no pop.
- IO read 0x30004: mem_din <= counter[7:0], and snapshot <= counter.
- IO reads 0x30005/6/7: mem_din <= snapshot[15:8]/[23:16]/[31:24]. This gives tear-free multi-byte reads.
- IO write 0x30000: mem_dout!=0 pushes mem_dout; mem_dout==0 is ignored.
- IO write 0x30004: program_done <= 1 and pushes 0x00 (the only zero ever queued).
- Other IO addresses: reads return 0; writes ignored.
- TX FIFO:
  - Push is accepted if count<TX_DEPTH, or if count==TX_DEPTH and a pop occurs the same edge.
  - Otherwise the byte is dropped and tx_overflow <= 1.
  - Pop occurs when tx_valid & tx_ready. Simultaneous push and pop leaves count unchanged. FIFO order is preserved across pointer wrap.
  - tx_valid = (count!=0); tx_data = head entry (combinational from storage).
  - io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), registered from next-count so it updates the edge after the push.

Test Plan:
- Write 0xA5 to 0x00010, then 0x3C to 0x1FFFF; read both -> mem_din=0xA5 one cycle after the first read address, 0x3C after the second. Back-to-back read of 0x00010 the edge after writing 0x77 -> 0x77.
- Hold rdy_in=0 for 5 cycles with mem_wr=1 to 0x00020 data 0xFF -> RAM byte unchanged, mem_din frozen, counter frozen; then read 0x30004..7 -> snapshot equals pre-stall count.
- rx_valid=1, rx_data=0x41, read 0x30000 -> mem_din=0x41, rx_pop single-cycle pulse. rx_valid=0, read 0x30000 -> mem_din=0x00, no pulse.
- tx_ready=0, write bytes 1..8 to 0x30000 -> io_buffer_full rises after the 6th push, tx_valid=1. A 9th write is dropped and tx_overflow=1. Write 0x00 -> no push. Raise tx_ready -> tx_data sequence 1..8.
- Write 0x30004 -> program_done=1, a 0x00 emerges on tx_data after queued bytes. Assert rst_in asynchronously mid-stream -> tx_valid, program_done, and mem_din drop to 0 immediately without a clock edge.
- Counter wrap: preload-free run via force to 0xFFFFFFFE, two rdy cycles, read 0x30004..7 -> 0x00,0x00,0x00,0x00.
